mux_rr_arbiter: RTL and testbench

Two-requester round-robin arbiter that owns the select line of the shared 2:1 mux datapath. It decides which of two sources (`data0`/`data1`) drives the mux output. It holds a grant for as long as the owner keeps requesting. It alternates fairly when both compete. The block sits directly in front of the 2:1 mux and replaces free-running `sel` stimulus with a registered, handshaked select.

---
 rtl/mux_arb_pkg.sv | 14 +
 rtl/mux_rr_arbiter_if.sv | 29 ++
 rtl/mux_arb_hold_cnt.sv | 31 +++
 rtl/mux_rr_arbiter.sv | 96 +++++++++
 tb/tb_mux_rr_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
// Holds the FSM state encoding, hold-counter width and default hold limit.
package mux_arb_pkg;

  localparam int CNT_W        = 8;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Bus bundle between the requesters/sources and the round-robin mux arbiter.
// The arbiter uses the slave modport; the requester side uses master.
interface mux_rr_arbiter_if #(
  parameter int W = 1
);

  // Handshake: reqX is a level request that may drop at any cycle; gntX is the
  // registered answer, and dataX is only meaningful on dout while gntX is high.
  logic         req0;
  logic         req1;
  logic [W-1:0] data0;
  logic [W-1:0] data1;
  logic         gnt0;
  logic         gnt1;
  logic         sel;
  logic [W-1:0] dout;
  logic         busy;

  modport master (
    output req0, req1, data0, data1,
    input  gnt0, gnt1, sel, dout, busy
  );

  modport slave (
    input  req0, req1, data0, data1,
    output gnt0, gnt1, sel, dout, busy
  );

endinterface

// File: rtl/mux_arb_hold_cnt.sv
// Grant hold counter: cleared on grant entry, counts grant cycles and
// saturates at MAX_HOLD-1, where it flags that a forced handover is allowed.
module mux_arb_hold_cnt
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter driving the select of a 2:1 mux.
// Optional forced handover after MAX_HOLD cycles when MUX_ARB_TIMEOUT_EN is defined.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int W        = 1,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  mux_rr_arbiter_if.slave   bus,
  output arb_state_t        o_dbg_state
);

  arb_state_t   r_state;
  arb_state_t   w_next;
  logic         r_last;
  logic         r_sel;
  logic         w_entry;
  logic         w_expired;
  logic [W-1:0] w_dout;

`ifdef MUX_ARB_TIMEOUT_EN
  mux_arb_hold_cnt #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_entry),
    .i_inc     (r_state != IDLE),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // A forced handover only happens when the other side is actually waiting.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          w_next = r_last ? GRANT0 : GRANT1;
        end else if (bus.req0) begin
          w_next = GRANT0;
        end else if (bus.req1) begin
          w_next = GRANT1;
        end
      end
      GRANT0: begin
        if (!bus.req0 || (w_expired && bus.req1)) begin
          w_next = bus.req1 ? GRANT1 : IDLE;
        end
      end
      GRANT1: begin
        if (!bus.req1 || (w_expired && bus.req0)) begin
          w_next = bus.req0 ? GRANT0 : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_entry = (w_next != r_state) && (w_next != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_entry) begin
        r_last <= (w_next == GRANT1);
        r_sel  <= (w_next == GRANT1);
      end
    end
  end

  always_comb begin
    w_dout = '0;
    unique case (r_state)
      GRANT0:  w_dout = bus.data0;
      GRANT1:  w_dout = bus.data1;
      default: w_dout = '0;
    endcase
  end

  assign bus.gnt0    = (r_state == GRANT0);
  assign bus.gnt1    = (r_state == GRANT1);
  assign bus.busy    = (r_state != IDLE);
  assign bus.sel     = r_sel;
  assign bus.dout    = w_dout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (W=4, MAX_HOLD=4).
// Honours MUX_ARB_TIMEOUT_EN to pick the expected timeout behaviour.
module tb_mux_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int W  = 4;
  localparam int MH = 4;
  localparam int OW = 4 + W;

  logic       clk;
  logic       rst;
  arb_state_t dbg_state;
  int         checks;
  int         failures;

  mux_rr_arbiter_if #(.W(W)) bus ();

  mux_rr_arbiter #(
    .W        (W),
    .MAX_HOLD (MH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {gnt0, gnt1, busy, sel, dout}.
  function automatic logic [OW-1:0] obs();
    return {bus.gnt0, bus.gnt1, bus.busy, bus.sel, bus.dout};
  endfunction

  function automatic logic [OW-1:0] exp_vec(input logic g0, input logic g1,
                                            input logic s, input logic [W-1:0] d);
    return {g0, g1, g0 | g1, s, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [OW-1:0] e;
    rst       = 1'b1;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.data0 = 4'hA;
    bus.data1 = 4'h5;
    e = exp_vec(1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, obs(), e);
      end
      checks++;
      if (dbg_state !== IDLE) begin
        failures++;
        $display("FAIL reset_state[%0d]: got %0d expected %0d", i, dbg_state, IDLE);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL reset_idle[%0d]: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_single();
    logic [OW-1:0] e;
    do_reset();
    bus.data0 = 4'h0;
    bus.data1 = 4'h1;
    bus.req1  = 1'b1;
    e = exp_vec(1'b0, 1'b1, 1'b1, 4'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL single_grant[%0d]: got %h expected %h", i, obs(), e);
      end
    end
    bus.req1 = 1'b0;
    e = exp_vec(1'b0, 1'b0, 1'b1, 4'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL single_release[%0d]: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_tie();
    logic [OW-1:0] e;
    do_reset();
    bus.data0 = 4'h3;
    bus.data1 = 4'hC;
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    e = exp_vec(1'b1, 1'b0, 1'b0, 4'h3);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL tie_first[%0d]: got %h expected %h", i, obs(), e);
      end
    end
    bus.req0 = 1'b0;
    step();
    e = exp_vec(1'b0, 1'b1, 1'b1, 4'hC);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL tie_handover: got %h expected %h", obs(), e);
    end
    bus.req1 = 1'b0;
    step();
    e = exp_vec(1'b0, 1'b0, 1'b1, 4'h0);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL tie_idle: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_alternation();
    logic [W-1:0]  d0_tab [4];
    logic [W-1:0]  d1_tab [4];
    logic [OW-1:0] e;
    logic          g0;
    d0_tab = '{4'h1, 4'h2, 4'h3, 4'h4};
    d1_tab = '{4'h8, 4'h9, 4'hA, 4'hB};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      g0        = (k % 2 == 0);
      bus.data0 = d0_tab[k];
      bus.data1 = d1_tab[k];
      bus.req0  = 1'b1;
      bus.req1  = 1'b1;
      step();
      e = exp_vec(g0, !g0, !g0, g0 ? d0_tab[k] : d1_tab[k]);
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL alt_grant[%0d]: got %h expected %h", k, obs(), e);
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      step();
      e = exp_vec(1'b0, 1'b0, !g0, 4'h0);
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL alt_idle[%0d]: got %h expected %h", k, obs(), e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [OW-1:0] e;
    do_reset();
    bus.data0 = 4'h6;
    bus.data1 = 4'h9;
    bus.req1  = 1'b1;
    step();
    bus.req0 = 1'b1;
    step();
    e = exp_vec(1'b0, 1'b1, 1'b1, 4'h9);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL mid_pre: got %h expected %h", obs(), e);
    end
    rst = 1'b1;
    step();
    e = exp_vec(1'b0, 1'b0, 1'b0, 4'h0);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL mid_reset: got %h expected %h", obs(), e);
    end
    rst = 1'b0;
    step();
    e = exp_vec(1'b1, 1'b0, 1'b0, 4'h6);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL mid_rearb: got %h expected %h", obs(), e);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    logic [OW-1:0] e0;
    logic [OW-1:0] e1;
    do_reset();
    bus.data0 = 4'h2;
    bus.data1 = 4'h7;
    bus.req0  = 1'b1;
    e0 = exp_vec(1'b1, 1'b0, 1'b0, 4'h2);
    e1 = exp_vec(1'b0, 1'b1, 1'b1, 4'h7);
    step();
    checks++;
    if (obs() !== e0) begin
      failures++;
      $display("FAIL to_first: got %h expected %h", obs(), e0);
    end
    bus.req1 = 1'b1;
    for (int i = 0; i < MH - 1; i++) begin
      step();
      checks++;
      if (obs() !== e0) begin
        failures++;
        $display("FAIL to_hold0[%0d]: got %h expected %h", i, obs(), e0);
      end
    end
`ifdef MUX_ARB_TIMEOUT_EN
    step();
    checks++;
    if (obs() !== e1) begin
      failures++;
      $display("FAIL to_force1: got %h expected %h", obs(), e1);
    end
    for (int i = 0; i < MH - 1; i++) begin
      step();
      checks++;
      if (obs() !== e1) begin
        failures++;
        $display("FAIL to_hold1[%0d]: got %h expected %h", i, obs(), e1);
      end
    end
    step();
    e0 = exp_vec(1'b1, 1'b0, 1'b0, 4'h2);
    checks++;
    if (obs() !== e0) begin
      failures++;
      $display("FAIL to_force0: got %h expected %h", obs(), e0);
    end
`else
    for (int i = 0; i < MH + 2; i++) begin
      step();
      checks++;
      if (obs() !== e0) begin
        failures++;
        $display("FAIL to_persist[%0d]: got %h expected %h", i, obs(), e0);
      end
    end
`endif
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.data0 = '0;
    bus.data1 = '0;
    test_reset();
    test_single();
    test_tie();
    test_alternation();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
